// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline hazard controller signal bundle
//
// Purpose: groups every stage-address / Tuse / Tnew input and every
// stall / forward / busy output of hazard_ctrl into one interface.
// Ports (all carried as interface signals):
//   D_a1, D_a2, D_tuse1, D_tuse2, D_md       D-stage sources and HI/LO use
//   E_a1, E_a2                               E-stage sources
//   E_a3, M_a3, W_a3, E_tnew, M_tnew         destinations and their Tnew
//   E_md_start, E_md_div                     mult/div issue in E
//   stall, F_en, D_en, E_clr                 pipeline freeze controls
//   D_fwd1, D_fwd2, E_fwd1, E_fwd2           operand source selects
//   md_busy, stall_cnt                       HI/LO busy, stalled-cycle count
// Modports: master drives the pipeline side, slave is the controller.
interface hazard_ctrl_if #(
    parameter int AW = 5,
    parameter int TW = 2,
    parameter int CW = 16
);
    logic [AW-1:0] D_a1;
    logic [AW-1:0] D_a2;
    logic [TW-1:0] D_tuse1;
    logic [TW-1:0] D_tuse2;
    logic          D_md;
    logic [AW-1:0] E_a1;
    logic [AW-1:0] E_a2;
    logic [AW-1:0] E_a3;
    logic [AW-1:0] M_a3;
    logic [AW-1:0] W_a3;
    logic [TW-1:0] E_tnew;
    logic [TW-1:0] M_tnew;
    logic          E_md_start;
    logic          E_md_div;
    logic          stall;
    logic          F_en;
    logic          D_en;
    logic          E_clr;
    logic [1:0]    D_fwd1;
    logic [1:0]    D_fwd2;
    logic [1:0]    E_fwd1;
    logic [1:0]    E_fwd2;
    logic          md_busy;
    logic [CW-1:0] stall_cnt;

    modport master (
        output D_a1, D_a2, D_tuse1, D_tuse2, D_md,
        output E_a1, E_a2, E_a3, M_a3, W_a3, E_tnew, M_tnew,
        output E_md_start, E_md_div,
        input  stall, F_en, D_en, E_clr,
        input  D_fwd1, D_fwd2, E_fwd1, E_fwd2,
        input  md_busy, stall_cnt
    );

    modport slave (
        input  D_a1, D_a2, D_tuse1, D_tuse2, D_md,
        input  E_a1, E_a2, E_a3, M_a3, W_a3, E_tnew, M_tnew,
        input  E_md_start, E_md_div,
        output stall, F_en, D_en, E_clr,
        output D_fwd1, D_fwd2, E_fwd1, E_fwd2,
        output md_busy, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline stall/forward controller with HI/LO busy tracking
//
// Purpose: raises a combinational stall when a D-stage source needs a value
// sooner than the E or M producer can supply it (Tuse < Tnew), or when D
// touches HI/LO while the mult/div unit is busy. Picks forwarding sources
// for D (E > M > W > regfile) and E (M > W > pipe reg) operands, tracks
// mult/div busy cycles and counts stalled cycles (saturating).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   bus    hazard_ctrl_if.slave, see rtl/hazard_ctrl_if.sv
module hazard_ctrl #(
    parameter int AW       = 5,
    parameter int TW       = 2,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CW       = 16
) (
    input  logic           clk,
    input  logic           reset,
    hazard_ctrl_if.slave   bus
);

    localparam logic [AW-1:0] ZERO_A = '0;
    localparam logic [TW-1:0] ZERO_T = '0;

    logic [7:0]    r_busy_cnt;
    logic [CW-1:0] r_stall_cnt;

    logic w_e_haz1, w_e_haz2, w_m_haz1, w_m_haz2, w_md_haz;
    logic w_stall, w_md_busy;

    // A producer that will still be Tnew cycles away when D needs the value
    // (Tuse) cannot be bypassed in time; register 0 is never a real producer.
    assign w_e_haz1 = (bus.D_a1 == bus.E_a3) && (bus.E_a3 != ZERO_A) && (bus.D_tuse1 < bus.E_tnew);
    assign w_e_haz2 = (bus.D_a2 == bus.E_a3) && (bus.E_a3 != ZERO_A) && (bus.D_tuse2 < bus.E_tnew);
    assign w_m_haz1 = (bus.D_a1 == bus.M_a3) && (bus.M_a3 != ZERO_A) && (bus.D_tuse1 < bus.M_tnew);
    assign w_m_haz2 = (bus.D_a2 == bus.M_a3) && (bus.M_a3 != ZERO_A) && (bus.D_tuse2 < bus.M_tnew);

    // The issuing cycle counts as busy so a HI/LO reader right behind the
    // mult/div stalls before the counter has been loaded.
    assign w_md_busy = (r_busy_cnt != 8'd0) || bus.E_md_start;
    assign w_md_haz  = bus.D_md && w_md_busy;

    assign w_stall = w_e_haz1 | w_e_haz2 | w_m_haz1 | w_m_haz2 | w_md_haz;

    // D operand: only a value already produced (Tnew == 0) may be forwarded;
    // a not-yet-ready nearer stage falls through to the next older one.
    function automatic logic [1:0] sel_d(input logic [AW-1:0] a);
        if ((a == bus.E_a3) && (bus.E_a3 != ZERO_A) && (bus.E_tnew == ZERO_T))
            sel_d = 2'd1;
        else if ((a == bus.M_a3) && (bus.M_a3 != ZERO_A) && (bus.M_tnew == ZERO_T))
            sel_d = 2'd2;
        else if ((a == bus.W_a3) && (bus.W_a3 != ZERO_A))
            sel_d = 2'd3;
        else
            sel_d = 2'd0;
    endfunction

    function automatic logic [1:0] sel_e(input logic [AW-1:0] a);
        if ((a == bus.M_a3) && (bus.M_a3 != ZERO_A) && (bus.M_tnew == ZERO_T))
            sel_e = 2'd2;
        else if ((a == bus.W_a3) && (bus.W_a3 != ZERO_A))
            sel_e = 2'd3;
        else
            sel_e = 2'd0;
    endfunction

    assign bus.D_fwd1    = sel_d(bus.D_a1);
    assign bus.D_fwd2    = sel_d(bus.D_a2);
    assign bus.E_fwd1    = sel_e(bus.E_a1);
    assign bus.E_fwd2    = sel_e(bus.E_a2);
    assign bus.stall     = w_stall;
    assign bus.F_en      = ~w_stall;
    assign bus.D_en      = ~w_stall;
    assign bus.E_clr     = w_stall;
    assign bus.md_busy   = w_md_busy;
    assign bus.stall_cnt = r_stall_cnt;

    // A new start always reloads, even over a running operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy_cnt <= 8'd0;
        end else if (bus.E_md_start) begin
            r_busy_cnt <= bus.E_md_div ? 8'(DIV_CYC) : 8'(MULT_CYC);
        end else if (r_busy_cnt != 8'd0) begin
            r_busy_cnt <= r_busy_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CW{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  AW  5  register-address width
  TW  2  Tuse/Tnew field width
  MULT_CYC  5  HI/LO busy cycles after a multiply starts
  DIV_CYC  10  HI/LO busy cycles after a divide starts
  CW  16  stall-cycle counter width
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-high
  D_a1, D_a2  in  AW  D-stage source registers
  D_tuse1, D_tuse2  in  TW  cycles until D needs each source
  D_md  in  1  D instruction reads or writes HI/LO
  E_a1, E_a2  in  AW  E-stage source registers
  E_a3, M_a3, W_a3  in  AW  destination registers; 0 means no write
  E_tnew, M_tnew  in  TW  cycles until the destination value exists
  E_md_start, E_md_div  in  1  mult/div issuing in E; 1 = divide
  stall  out  1  freeze F/D, bubble E
  F_en, D_en, E_clr  out  1  equal to ~stall, ~stall, stall
  D_fwd1, D_fwd2  out  2  D operand source: 0 regfile, 1 E, 2 M, 3 W
  E_fwd1, E_fwd2  out  2  E operand source: 0 pipe reg, 2 M, 3 W
  md_busy  out  1  HI/LO unit busy
  stall_cnt  out  CW  total stalled cycles, saturating

Function
REQ-003 An E hazard on source k SHALL be raised when D_ak == E_a3, E_a3 != 0 and D_tusek < E_tnew.
REQ-004 An M hazard on source k SHALL be raised when D_ak == M_a3, M_a3 != 0 and D_tusek < M_tnew.
REQ-005 A W stage SHALL never cause a stall.
REQ-006 An MD hazard SHALL be raised when D_md = 1 and md_busy = 1.
REQ-007 stall SHALL equal the combinational OR of all E, M and MD hazards in the same cycle, with no register between inputs and stall.
REQ-008 D_fwdk SHALL be chosen by priority E > M > W > regfile.
  - E is chosen only when D_ak == E_a3, E_a3 != 0 and E_tnew == 0.
  - M is chosen only when D_ak == M_a3, M_a3 != 0 and M_tnew == 0.
  - W is chosen when D_ak == W_a3 and W_a3 != 0.
REQ-009 E_fwdk SHALL be chosen by priority M > W > pipe reg, using the same match and Tnew rules, with E_ak in place of D_ak.
REQ-010 Address 0 SHALL never produce a hazard and SHALL never be forwarded.
REQ-011 Register busy_cnt (8 bits) SHALL load a value when E_md_start = 1.
  - It loads DIV_CYC when E_md_div = 1, otherwise MULT_CYC.
  - Otherwise it decrements by 1 while nonzero and holds at 0.
REQ-012 md_busy SHALL equal (busy_cnt != 0) OR E_md_start.
REQ-013 When E_md_start = 1 while busy_cnt != 0, the counter SHALL reload; the new start wins.
REQ-014 stall_cnt SHALL increment by 1 on every rising edge where stall = 1.
  - It saturates at all-ones and does not wrap.
REQ-015 Every input pair matching several stages at once SHALL resolve by the priority in REQ-008 and REQ-009 within the same cycle.

Reset
REQ-016 On a rising clk with reset = 1, busy_cnt and stall_cnt SHALL clear to 0; reset overrides E_md_start.
REQ-017 After reset, with inputs all 0:
  - stall = 0, md_busy = 0.
  - All fwd selects = 0.
  - F_en = 1, D_en = 1, E_clr = 0.
REQ-018 A reset during a multiply or divide SHALL abort it, so md_busy = 0 the cycle after reset when E_md_start = 0.

Verification
REQ-019 Load-use: D_a1=5, D_tuse1=0, E_a3=5, E_tnew=2 -> stall=1, E_clr=1, and stall_cnt increments by 1 per edge.
REQ-020 Forwarding priority:
  - D_a2=7, E_a3=7, E_tnew=0, M_a3=7, M_tnew=0, W_a3=7 -> D_fwd2=1, stall=0.
  - Setting E_tnew=1 with D_tuse2=1 -> D_fwd2=2, stall=0.
REQ-021 Zero register: D_a1=0, E_a3=0, E_tnew=2, D_tuse1=0 -> stall=0, D_fwd1=0.
REQ-022 Divide busy: one pulse E_md_start=1, E_md_div=1, then D_md=1 held.
  - stall=1 in the pulse cycle and for the 10 following cycles.
  - stall=0 in the 11th cycle after the pulse.
  - A multiply gives 5 following cycles instead.
REQ-023 Reset mid-operation: assert reset 3 cycles into a multiply -> md_busy=0 and stall_cnt=0 on the next cycle.
REQ-024 Saturation: with CW=4, hold stall for 20 cycles -> stall_cnt = 15 and it stays at 15.
